// File: rtl/output_module_pkg.sv
// Shared NoC router definitions: direction codes, default sizes, FSM encodings
// and a small one-hot decode helper used by the output port.
package output_module_pkg;

  localparam int FLIT_W_DEF = 8;
  localparam int DEPTH_DEF  = 32;

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_S = 2'b01;
  localparam logic [1:0] DIR_E = 2'b10;
  localparam logic [1:0] DIR_W = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/output_module_rr_arbiter_4.sv
// Four-way round-robin arbiter: grants the first requester found searching
// upward from ptr, wrapping modulo 4.
module rr_arbiter_4
  import output_module_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    gnt = 4'b0000;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (req[idx] && (gnt == 4'b0000)) gnt[idx] = 1'b1;
    end
  end

  assign any = |req;

endmodule

// File: rtl/output_module.sv
// Router output port: locks one input for a whole packet, forwards one flit per
// cycle through a registered stage, and gates transfers on downstream credits.
module output_module
  import output_module_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   req_in,
  input  logic [4*FLIT_W-1:0]          data_in,
  input  logic [3:0]                   last_in,
  output logic [3:0]                   read_en,
  input  logic                         credit_in,
  output logic                         valid_out,
  output logic [FLIT_W-1:0]            data_out,
  output logic                         last_out,
  output logic [$clog2(DEPTH+1)-1:0]   credits,
  output logic                         error
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [0:0]        state;
  logic [1:0]        owner;
  logic [1:0]        rr_ptr;
  logic [1:0]        sel;
  logic [3:0]        gnt;
  logic              any;
  logic              sel_req;
  logic              sel_last;
  logic              xfer;
  logic [FLIT_W-1:0] sel_data;

  rr_arbiter_4 u_arb (
    .req (req_in),
    .ptr (rr_ptr),
    .gnt (gnt),
    .any (any)
  );

  // Once a packet is in flight only its owner is looked at; other requesters
  // wait even if the owner's buffer momentarily runs dry.
  always_comb begin
    sel      = (state == ST_IDLE) ? onehot_to_idx(gnt) : owner;
    sel_req  = (state == ST_IDLE) ? any : req_in[owner];
    sel_data = data_in[sel*FLIT_W +: FLIT_W];
    sel_last = last_in[sel];
    xfer     = sel_req && (credits != '0) && !reset;
    read_en  = xfer ? (4'b0001 << sel) : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      owner  <= DIR_N;
      rr_ptr <= DIR_N;
    end else if (xfer) begin
      state <= sel_last ? ST_IDLE : ST_SEND;
      owner <= sel;
      if (sel_last) rr_ptr <= sel + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      valid_out <= xfer;
      if (xfer) begin
        data_out <= sel_data;
        last_out <= sel_last;
      end
    end
  end

  // A credit returned while already full means downstream lost track of slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= FULL;
      error   <= 1'b0;
    end else begin
      case ({xfer, credit_in})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == FULL) error <= 1'b1;
          else                 credits <= credits + 1'b1;
        end
        default: credits <= credits;
      endcase
    end
  end

endmodule
